// File: rtl/xprog_loader.sv
// Boot-time program loader: assembles a count/words/checksum byte stream into program memory
// writes and holds the controller in reset until a verified image has been written.
module xprog_loader #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PADDR_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    input  logic               boot_req,
    output logic               prog_we,
    output logic [PADDR_W-1:0] prog_addr,
    output logic [INSTR_W-1:0] prog_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);

    localparam int unsigned Bytes = INSTR_W / 8;
    localparam int unsigned Depth = 1 << PADDR_W;
    localparam logic [7:0]  LastByte = 8'(Bytes - 1);

    typedef logic [INSTR_W-1:0] word_t;
    typedef enum logic [2:0] {
        StIdle, StCntHi, StCntLo, StData, StCsum, StDone, StErr
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         csum_q, csum_d;
    word_t              word_q, word_d;
    logic               prog_we_q, prog_we_d;
    logic [PADDR_W-1:0] prog_addr_q, prog_addr_d;
    word_t              prog_wdata_q, prog_wdata_d;
    logic [15:0]        n_word;
    logic               accept;

    assign rx_ready   = (state_q == StCntHi) || (state_q == StCntLo) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign accept     = rx_valid && rx_ready;
    assign cpu_rst    = (state_q != StDone);
    assign done       = (state_q == StDone);
    assign err        = (state_q == StErr);
    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_wdata = prog_wdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        csum_d       = csum_q;
        word_d       = word_q;
        prog_we_d    = 1'b0;
        prog_wdata_d = prog_wdata_q;
        // Address steps in the cycle after each write strobe.
        prog_addr_d  = prog_we_q ? prog_addr_q + PADDR_W'(1) : prog_addr_q;
        n_word       = {cnt_q[15:8], rx_data};

        case (state_q)
            StIdle: begin
                state_d     = StCntHi;
                word_cnt_d  = '0;
                byte_cnt_d  = '0;
                csum_d      = '0;
                prog_addr_d = '0;
            end
            StCntHi: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    csum_d      = csum_q ^ rx_data;
                    state_d     = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    cnt_d  = n_word;
                    csum_d = csum_q ^ rx_data;
                    if (32'(n_word) > Depth) begin
                        state_d = StErr;
                    end else if (n_word == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    word_d = (word_q << 8) | word_t'(rx_data);
                    if (byte_cnt_q == LastByte) begin
                        byte_cnt_d   = '0;
                        prog_we_d    = 1'b1;
                        prog_wdata_d = word_d;
                        word_cnt_d   = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == cnt_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? StDone : StErr;
                end
            end
            StDone, StErr: begin
                if (boot_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            prog_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            csum_q       <= csum_d;
            word_q       <= word_d;
            prog_we_q    <= prog_we_d;
            prog_addr_q  <= prog_addr_d;
            prog_wdata_q <= prog_wdata_d;
        end
    end

endmodule
